// File: rtl/bmu_pkg.sv
// Shared encodings for the bit-manipulation extension datapath.
package bmu_pkg;

    localparam int unsigned EXT_SEL_W = 2;

    typedef logic [EXT_SEL_W-1:0] ext_sel_t;

    localparam ext_sel_t EXT_SEXTB = 2'b00;
    localparam ext_sel_t EXT_SEXTH = 2'b01;
    localparam ext_sel_t EXT_ZEXTH = 2'b10;

endpackage

// File: rtl/ext.sv
// Sign/zero extension unit: sext.b, sext.h, zext.h on a WIDTH-bit operand.
module ext
    import bmu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  ext_sel_t         ext_select,
    output logic [WIDTH-1:0] result_c
);

    always_comb begin
        result_c = {{(WIDTH-16){1'b0}}, a[15:0]};
        case (ext_select)
            EXT_SEXTB: result_c = {{(WIDTH-8){a[7]}}, a[7:0]};
            EXT_SEXTH: result_c = {{(WIDTH-16){a[15]}}, a[15:0]};
            EXT_ZEXTH: result_c = {{(WIDTH-16){1'b0}}, a[15:0]};
            default:   result_c = {{(WIDTH-16){1'b0}}, a[15:0]};
        endcase
    end

endmodule

// File: rtl/ext_arbiter.sv
// Round-robin arbiter sharing one extension unit between two requesters,
// with a single registered result slot routed back to the issuing requester.
module ext_arbiter
    import bmu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAGW  = 4
) (
    input  logic             clk,
    input  logic             resetn,

    input  logic             Req0Valid,
    output logic             Req0Ready,
    input  logic [WIDTH-1:0] Req0A,
    input  logic [1:0]       Req0ExtSelect,
    input  logic [TAGW-1:0]  Req0Tag,

    input  logic             Req1Valid,
    output logic             Req1Ready,
    input  logic [WIDTH-1:0] Req1A,
    input  logic [1:0]       Req1ExtSelect,
    input  logic [TAGW-1:0]  Req1Tag,

    output logic             Rsp0Valid,
    input  logic             Rsp0Ready,
    output logic [WIDTH-1:0] Rsp0Result,
    output logic [TAGW-1:0]  Rsp0Tag,

    output logic             Rsp1Valid,
    input  logic             Rsp1Ready,
    output logic [WIDTH-1:0] Rsp1Result,
    output logic [TAGW-1:0]  Rsp1Tag
);

    logic             pri_q,        pri_d;
    logic             out_valid_q,  out_valid_d;
    logic             out_owner_q,  out_owner_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic [TAGW-1:0]  out_tag_q,    out_tag_d;

    logic             any_valid_c;
    logic             grant_c;
    logic             free_c;
    logic             accept_c;
    logic [WIDTH-1:0] mux_a_c;
    ext_sel_t         mux_sel_c;
    logic [WIDTH-1:0] ext_result_c;

    // Grant: a lone requester wins; on contention the favoured one wins.
    always_comb begin
        any_valid_c = Req0Valid | Req1Valid;
        grant_c     = (Req0Valid & Req1Valid) ? pri_q : Req1Valid;
        free_c      = ~out_valid_q | (out_owner_q ? Rsp1Ready : Rsp0Ready);
        accept_c    = free_c & any_valid_c;
        Req0Ready   = free_c & any_valid_c & ~grant_c;
        Req1Ready   = free_c & any_valid_c & grant_c;
        mux_a_c     = grant_c ? Req1A : Req0A;
        mux_sel_c   = grant_c ? ext_sel_t'(Req1ExtSelect) : ext_sel_t'(Req0ExtSelect);
    end

    ext #(
        .WIDTH (WIDTH)
    ) u_ext (
        .a          (mux_a_c),
        .ext_select (mux_sel_c),
        .result_c   (ext_result_c)
    );

    // Slot update: load on accept, empty when drained without a new accept.
    always_comb begin
        pri_d        = pri_q;
        out_valid_d  = out_valid_q;
        out_owner_d  = out_owner_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        if (accept_c) begin
            out_valid_d  = 1'b1;
            out_owner_d  = grant_c;
            out_result_d = ext_result_c;
            out_tag_d    = grant_c ? Req1Tag : Req0Tag;
            pri_d        = ~grant_c;
        end else if (free_c) begin
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pri_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_owner_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else begin
            pri_q        <= pri_d;
            out_valid_q  <= out_valid_d;
            out_owner_q  <= out_owner_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
        end
    end

    assign Rsp0Valid  = out_valid_q & ~out_owner_q;
    assign Rsp1Valid  = out_valid_q & out_owner_q;
    assign Rsp0Result = out_result_q;
    assign Rsp1Result = out_result_q;
    assign Rsp0Tag    = out_tag_q;
    assign Rsp1Tag    = out_tag_q;

endmodule

// File: tb/tb_ext_arbiter.sv
// Directed, table-driven bench for ext_arbiter (32-bit and 64-bit instances).
module tb_ext_arbiter;

    logic        clk;
    logic        resetn;

    logic        r0v, r0rdy, r1v, r1rdy;
    logic [31:0] r0a, r1a;
    logic [1:0]  r0s, r1s;
    logic [3:0]  r0t, r1t;
    logic        s0v, s0k, s1v, s1k;
    logic [31:0] s0res, s1res;
    logic [3:0]  s0tag, s1tag;

    logic        w1v, w1rdy, w0rdy, ws0v, ws1v;
    logic [63:0] w1a, ws0res, ws1res;
    logic [1:0]  w1s;
    logic [3:0]  w1t, ws0tag, ws1tag;

    int errors = 0;
    int checks = 0;

    ext_arbiter #(.WIDTH(32), .TAGW(4)) u_dut (
        .clk (clk), .resetn (resetn),
        .Req0Valid (r0v), .Req0Ready (r0rdy), .Req0A (r0a), .Req0ExtSelect (r0s), .Req0Tag (r0t),
        .Req1Valid (r1v), .Req1Ready (r1rdy), .Req1A (r1a), .Req1ExtSelect (r1s), .Req1Tag (r1t),
        .Rsp0Valid (s0v), .Rsp0Ready (s0k), .Rsp0Result (s0res), .Rsp0Tag (s0tag),
        .Rsp1Valid (s1v), .Rsp1Ready (s1k), .Rsp1Result (s1res), .Rsp1Tag (s1tag)
    );

    ext_arbiter #(.WIDTH(64), .TAGW(4)) u_dut64 (
        .clk (clk), .resetn (resetn),
        .Req0Valid (1'b0), .Req0Ready (w0rdy), .Req0A (64'd0), .Req0ExtSelect (2'b00), .Req0Tag (4'd0),
        .Req1Valid (w1v), .Req1Ready (w1rdy), .Req1A (w1a), .Req1ExtSelect (w1s), .Req1Tag (w1t),
        .Rsp0Valid (ws0v), .Rsp0Ready (1'b1), .Rsp0Result (ws0res), .Rsp0Tag (ws0tag),
        .Rsp1Valid (ws1v), .Rsp1Ready (1'b1), .Rsp1Result (ws1res), .Rsp1Tag (ws1tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r0v; logic [31:0] r0a; logic [1:0] r0s; logic [3:0] r0t;
        logic        r1v; logic [31:0] r1a; logic [1:0] r1s; logic [3:0] r1t;
        logic        k0;  logic        k1;
        logic        e_r0rdy; logic e_r1rdy;
        logic        e_s0v; logic [31:0] e_s0res; logic [3:0] e_s0tag;
        logic        e_s1v; logic [31:0] e_s1res; logic [3:0] e_s1tag;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        r0v = 1'b0; r0a = '0; r0s = 2'b00; r0t = '0;
        r1v = 1'b0; r1a = '0; r1s = 2'b00; r1t = '0;
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        s0k = 1'b1; s1k = 1'b1;
        w1v = 1'b0; w1a = '0; w1s = 2'b00; w1t = '0;

        // Round-robin alternation and simultaneous drain/accept
        vecs[0] = '{1'b1, 32'h0000_0080, 2'b00, 4'd3, 1'b0, 32'h0, 2'b00, 4'd0, 1'b1, 1'b1,
                    1'b1, 1'b0, 1'b0, 32'h0, 4'd0, 1'b0, 32'h0, 4'd0};
        vecs[1] = '{1'b0, 32'h0, 2'b00, 4'd0, 1'b1, 32'h0000_007F, 2'b00, 4'd5, 1'b1, 1'b1,
                    1'b0, 1'b1, 1'b1, 32'hFFFF_FF80, 4'd3, 1'b0, 32'h0, 4'd0};
        vecs[2] = '{1'b1, 32'h0000_8001, 2'b01, 4'd1, 1'b1, 32'hFFFF_8001, 2'b10, 4'd2, 1'b1, 1'b1,
                    1'b1, 1'b0, 1'b0, 32'h0, 4'd0, 1'b1, 32'h0000_007F, 4'd5};
        vecs[3] = '{1'b1, 32'h0000_8001, 2'b01, 4'd1, 1'b1, 32'hFFFF_8001, 2'b10, 4'd2, 1'b1, 1'b1,
                    1'b0, 1'b1, 1'b1, 32'hFFFF_8001, 4'd1, 1'b0, 32'h0, 4'd0};
        vecs[4] = '{1'b1, 32'h0000_8001, 2'b01, 4'd1, 1'b1, 32'hFFFF_8001, 2'b10, 4'd2, 1'b1, 1'b1,
                    1'b1, 1'b0, 1'b0, 32'h0, 4'd0, 1'b1, 32'h0000_8001, 4'd2};
        vecs[5] = '{1'b1, 32'h0000_8001, 2'b01, 4'd1, 1'b1, 32'hFFFF_8001, 2'b10, 4'd2, 1'b1, 1'b1,
                    1'b0, 1'b1, 1'b1, 32'hFFFF_8001, 4'd1, 1'b0, 32'h0, 4'd0};
        vecs[6] = '{1'b0, 32'h0, 2'b00, 4'd0, 1'b0, 32'h0, 2'b00, 4'd0, 1'b1, 1'b1,
                    1'b0, 1'b0, 1'b0, 32'h0, 4'd0, 1'b1, 32'h0000_8001, 4'd2};
        vecs[7] = '{1'b0, 32'h0, 2'b00, 4'd0, 1'b0, 32'h0, 2'b00, 4'd0, 1'b1, 1'b1,
                    1'b0, 1'b0, 1'b0, 32'h0, 4'd0, 1'b0, 32'h0, 4'd0};

        tick();
        tick();
        chk("reset_rsp0_valid", 64'(s0v), 64'd0);
        chk("reset_rsp1_valid", 64'(s1v), 64'd0);
        chk("reset_rsp0_result", 64'(s0res), 64'd0);
        chk("reset_rsp0_tag", 64'(s0tag), 64'd0);
        resetn = 1'b1;
        tick();
        chk("idle_req0_ready", 64'(r0rdy), 64'd0);
        chk("idle_req1_ready", 64'(r1rdy), 64'd0);

        for (int i = 0; i < 8; i++) begin
            r0v = vecs[i].r0v; r0a = vecs[i].r0a; r0s = vecs[i].r0s; r0t = vecs[i].r0t;
            r1v = vecs[i].r1v; r1a = vecs[i].r1a; r1s = vecs[i].r1s; r1t = vecs[i].r1t;
            s0k = vecs[i].k0;  s1k = vecs[i].k1;
            #1;
            chk($sformatf("v%0d_req0_ready", i), 64'(r0rdy), 64'(vecs[i].e_r0rdy));
            chk($sformatf("v%0d_req1_ready", i), 64'(r1rdy), 64'(vecs[i].e_r1rdy));
            chk($sformatf("v%0d_rsp0_valid", i), 64'(s0v), 64'(vecs[i].e_s0v));
            chk($sformatf("v%0d_rsp1_valid", i), 64'(s1v), 64'(vecs[i].e_s1v));
            if (vecs[i].e_s0v) begin
                chk($sformatf("v%0d_rsp0_result", i), 64'(s0res), 64'(vecs[i].e_s0res));
                chk($sformatf("v%0d_rsp0_tag", i), 64'(s0tag), 64'(vecs[i].e_s0tag));
            end
            if (vecs[i].e_s1v) begin
                chk($sformatf("v%0d_rsp1_result", i), 64'(s1res), 64'(vecs[i].e_s1res));
                chk($sformatf("v%0d_rsp1_tag", i), 64'(s1tag), 64'(vecs[i].e_s1tag));
            end
            tick();
        end

        // Backpressure on requester 1 blocks requester 0
        idle();
        r1v = 1'b1; r1a = 32'h0000_00F0; r1s = 2'b00; r1t = 4'd9;
        #1;
        chk("bp_req1_ready", 64'(r1rdy), 64'd1);
        tick();
        idle();
        s1k = 1'b0;
        r0v = 1'b1; r0a = 32'h0000_1234; r0s = 2'b01; r0t = 4'd7;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d_req0_ready", c), 64'(r0rdy), 64'd0);
            chk($sformatf("bp%0d_rsp1_valid", c), 64'(s1v), 64'd1);
            chk($sformatf("bp%0d_rsp1_result", c), 64'(s1res), 64'hFFFF_FFF0);
            chk($sformatf("bp%0d_rsp1_tag", c), 64'(s1tag), 64'd9);
            chk($sformatf("bp%0d_rsp0_valid", c), 64'(s0v), 64'd0);
            tick();
        end
        s1k = 1'b1;
        #1;
        chk("bp_release_req0_ready", 64'(r0rdy), 64'd1);
        tick();
        idle();
        #1;
        chk("bp_rsp0_valid", 64'(s0v), 64'd1);
        chk("bp_rsp0_result", 64'(s0res), 64'h0000_1234);
        chk("bp_rsp0_tag", 64'(s0tag), 64'd7);
        chk("bp_rsp1_drained", 64'(s1v), 64'd0);
        tick();

        // Pri after a requester-1 then requester-0 accept favours 1
        r0v = 1'b1; r0a = 32'h0000_0011; r0s = 2'b00; r0t = 4'd2;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("solo%0d_req0_ready", c), 64'(r0rdy), 64'd1);
            tick();
        end
        r1v = 1'b1; r1a = 32'h0000_0022; r1s = 2'b00; r1t = 4'd6;
        #1;
        chk("pri_req1_ready", 64'(r1rdy), 64'd1);
        chk("pri_req0_ready", 64'(r0rdy), 64'd0);
        chk("pri_prev_rsp0_valid", 64'(s0v), 64'd1);
        tick();
        #1;
        chk("pri2_req0_ready", 64'(r0rdy), 64'd1);
        chk("pri2_rsp1_result", 64'(s1res), 64'h0000_0022);
        chk("pri2_rsp1_tag", 64'(s1tag), 64'd6);
        tick();
        idle();
        tick();

        // Asynchronous reset discards a held result
        s0k = 1'b0;
        r0v = 1'b1; r0a = 32'h0000_00FF; r0s = 2'b00; r0t = 4'd4;
        tick();
        idle();
        #1;
        chk("rst_held_rsp0_valid", 64'(s0v), 64'd1);
        resetn = 1'b0;
        #1;
        chk("rst_async_rsp0_valid", 64'(s0v), 64'd0);
        tick();
        resetn = 1'b1;
        s0k = 1'b1;
        tick();
        chk("rst_after_rsp0_valid", 64'(s0v), 64'd0);
        chk("rst_after_rsp1_valid", 64'(s1v), 64'd0);
        r0v = 1'b1; r0a = 32'h0000_0001; r0s = 2'b10; r0t = 4'd1;
        r1v = 1'b1; r1a = 32'h0000_0002; r1s = 2'b10; r1t = 4'd2;
        #1;
        chk("rst_pri_req0_ready", 64'(r0rdy), 64'd1);
        chk("rst_pri_req1_ready", 64'(r1rdy), 64'd0);
        tick();
        idle();
        #1;
        chk("rst_first_rsp0_result", 64'(s0res), 64'h0000_0001);
        tick();

        // 64-bit instance, zext.h via select 11
        w1v = 1'b1; w1a = 64'h1234_5678_9ABC_8000; w1s = 2'b11; w1t = 4'd8;
        #1;
        chk("w64_req1_ready", 64'(w1rdy), 64'd1);
        tick();
        w1v = 1'b0;
        #1;
        chk("w64_rsp1_valid", 64'(ws1v), 64'd1);
        chk("w64_rsp1_result", ws1res, 64'h0000_0000_0000_8000);
        chk("w64_rsp1_tag", 64'(ws1tag), 64'd8);
        chk("w64_rsp0_valid", 64'(ws0v), 64'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
